// File: rtl/delta_reverse_par_if.sv
// rtl/delta_reverse_par_if.sv - block-in / beat-out handshake bundle for delta_reverse_par
interface delta_reverse_par_if #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int LANES      = 2
);
  // Block side: one delta-bit-plane block per request
  logic [DATA_W-1:0]                     base_i;
  logic [(DATA_W+1)*(BLOCK_SIZE-1)-1:0]  dbp_i;
  logic                                  vld_i;
  logic                                  rdy_o;

  // Beat side: LANES reconstructed words per beat
  logic [LANES*DATA_W-1:0]               data_o;
  logic                                  vld_o;
  logic                                  last_o;
  logic                                  rdy_i;

  // Synchronous clear
  logic                                  clr_i;

  modport slave (
    input  base_i, dbp_i, vld_i, rdy_i, clr_i,
    output rdy_o, data_o, vld_o, last_o
  );

  modport master (
    output base_i, dbp_i, vld_i, rdy_i, clr_i,
    input  rdy_o, data_o, vld_o, last_o
  );
endinterface

// File: rtl/delta_reverse_par.sv
// rtl/delta_reverse_par.sv - multi-lane delta-reverse prefix summation; DELTA_REVERSE_SATURATE_EN clamps instead of wrapping
module delta_reverse_par #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int LANES      = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  delta_reverse_par_if.slave bus
);

  localparam int ND    = BLOCK_SIZE - 1;
  localparam int DW1   = DATA_W + 1;
  localparam int SW    = DATA_W + 2;
  localparam int BEATS = BLOCK_SIZE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;

  // Padded diff vector: entry 0 is zero so lane 0 of beat 0 passes base through
  // unchanged; entry m (m >= 1) holds diff d[m-1].
  logic [DW1*BLOCK_SIZE-1:0] dpad;
  logic [DW1*LANES-1:0]      lane_d;
  logic signed [DATA_W-1:0]  chain [LANES+1];
  logic signed [SW-1:0]      lsum  [LANES];
  logic [LANES*DATA_W-1:0]   beat_words;
  logic                      hs;
  logic                      is_last;

  assign dpad[DW1-1:0] = '0;

  for (genvar i = 0; i < ND; i++) begin : g_diff
    for (genvar j = 0; j < DW1; j++) begin : g_bit
      assign dpad[(i+1)*DW1 + j] = bus.dbp_i[j*ND + (ND-1-i)];
    end
  end

  // Select the LANES diffs feeding the current beat
  always_comb begin
    lane_d = (DW1*LANES)'(dpad >> (int'(beat_q) * (LANES*DW1)));
  end

  // Running value entering the beat: base on the first beat, accumulator afterwards
  always_comb begin
    chain[0] = (state_q == STREAM) ? acc_q : $signed(bus.base_i);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lsum[l] = SW'(chain[l]) + SW'($signed(lane_d[l*DW1 +: DW1]));
`ifdef DELTA_REVERSE_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_W-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (DATA_W-1)));
    assign chain[l+1] = (lsum[l] > SAT_MAX) ? DATA_W'(SAT_MAX) :
                        (lsum[l] < SAT_MIN) ? DATA_W'(SAT_MIN) :
                        DATA_W'(lsum[l]);
`else
    assign chain[l+1] = DATA_W'(lsum[l]);
`endif
    assign beat_words[l*DATA_W +: DATA_W] = chain[l+1];
  end

  // Accepted beat this cycle; the clear wins over any handshake
  assign hs      = bus.vld_i & bus.rdy_i & ~bus.clr_i;
  // beat_q is 0 in IDLE, so a single-beat block is final straight away
  assign is_last = (beat_q == BW'(BEATS-1));

  // State register: FSM state, beat counter and accumulator
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic: advance one beat per handshake, return to IDLE after the last
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    if (bus.clr_i) begin
      state_d = IDLE;
      beat_d  = '0;
      acc_d   = '0;
    end else if (hs) begin
      acc_d = chain[LANES];
      if (is_last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d = STREAM;
        beat_d  = beat_q + 1'b1;
      end
    end
  end

  // Output logic: beat is combinational off the held block, zeroed when not valid
  always_comb begin
    bus.vld_o  = bus.vld_i & ~bus.clr_i;
    bus.data_o = bus.vld_o ? beat_words : '0;
    bus.last_o = bus.vld_o & is_last;
    bus.rdy_o  = hs & is_last;
  end

endmodule
